// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// UART transmitter for the uart block. Each accepted load turns one byte into
// a serial frame on TX: a low start bit, eight data bits LSB first, an
// optional even parity bit, and one high stop bit. The line idles high.
// The module has its own baud timer, bit counter, shift register and FSM.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (default 868 = 100 MHz / 115200).
//                 Must be >= 2.
//
// Ports
//   CLK   in   1  system clock, rising edge
//   RST   in   1  synchronous active-high reset; aborts any frame in flight
//   DIN   in   8  byte to send, sampled only on the cycle a load is accepted
//   LD    in   1  load request, accepted when LD=1 and RDY=1
//   RDY   out  1  transmitter idle (registered)
//   TX    out  1  serial line, idle high (registered)
//   DONE  out  1  one-cycle pulse in the first cycle after a stop bit ends
//                 (registered)
//
// Build option
//   UART_TX_PARITY_EN  when defined, an even parity bit is sent between the
//                      last data bit and the stop bit (8E1, 11 bit periods).
//                      When undefined the frame is 8N1 (10 bit periods).
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DIN,
  input  logic       LD,
  output logic       RDY,
  output logic       TX,
  output logic       DONE
);

  // Timer width; at least one bit even for the smallest legal period.
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t        state_q,  state_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic [2:0]    bit_q,    bit_d;
  logic [7:0]    shift_q,  shift_d;
  logic          tx_q,     tx_d;
  logic          rdy_q,    rdy_d;
  logic          done_q,   done_d;
`ifdef UART_TX_PARITY_EN
  // Parity is taken from the byte at capture time; the shift register is
  // consumed during DATA so it cannot be used to recompute it later.
  logic          parity_q, parity_d;
`endif

  logic timer_tc;
  assign timer_tc = (timer_q == TIMER_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic. Outputs are computed for the *next* cycle so that TX,
  // RDY and DONE leave the module straight from flops: a change of state and
  // the matching line level appear together on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    // Every state or bit change happens exactly on the terminal count, so
    // wrapping the timer there also restarts it for the next bit period.
    timer_d  = timer_tc ? '0 : timer_q + TW'(1);

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (LD) begin
          shift_d  = DIN;
          bit_d    = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^DIN;
`endif
          state_d  = S_START;
          tx_d     = 1'b0;
        end
      end

      S_START: begin
        if (timer_tc) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end

      S_DATA: begin
        if (timer_tc) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // Next bit is the one about to land in shift[0].
            tx_d = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (timer_tc) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        tx_d = 1'b1;
        if (timer_tc) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        tx_d    = 1'b1;
      end
    endcase

    // RDY mirrors the state being entered, so it is high in the DONE cycle
    // and a load presented then is accepted (back-to-back frames).
    rdy_d = (state_d == S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers. Reset wins over any load in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      rdy_q    <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign TX   = tx_q;
  assign RDY  = rdy_q;
  assign DONE = done_q;

endmodule
